// File: rtl/veri_risc_pkg.sv
// Shared constants, opcode/phase encodings and ALU helper for the veri_risc accumulator CPU.
package veri_risc_pkg;

  localparam int unsigned DWIDTH    = 8;
  localparam int unsigned AWIDTH    = 5;
  localparam int unsigned OWIDTH    = 3;
  localparam int unsigned MEM_DEPTH = 32;

  typedef enum logic [OWIDTH-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Accumulator result for the store phase; non-ALU opcodes leave acc unchanged.
  function automatic logic [DWIDTH-1:0] alu_calc(
    input opcode_e           op,
    input logic [DWIDTH-1:0] acc,
    input logic [DWIDTH-1:0] data
  );
    logic [DWIDTH-1:0] res;
    res = acc;
    case (op)
      ADD:     res = DWIDTH'(acc + data);
      AND:     res = acc & data;
      XOR:     res = acc ^ data;
      LDA:     res = data;
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/veri_risc_memory.sv
// 32x8 unified instruction/data memory: combinational read, synchronous write.
module veri_risc_memory
  import veri_risc_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] memo [0:MEM_DEPTH-1];

  assign rdata_o = memo[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memo[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/veri_risc.sv
// Eight-phase accumulator CPU: controller, pc, ir, accumulator and ALU around a shared memory.
module veri_risc
  import veri_risc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic halt
);

  phase_e            phase_q, phase_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [DWIDTH-1:0] acc_q, acc_d;

  opcode_e           opcode_c;
  logic [AWIDTH-1:0] mem_addr_c;
  logic [DWIDTH-1:0] mem_rdata_c;
  logic              mem_we_c;
  logic              zero_c;
  logic              halt_c;

  assign opcode_c   = opcode_e'(ir_q[DWIDTH-1:AWIDTH]);
  assign zero_c     = (acc_q == '0);
  assign halt_c     = (phase_q == OP_ADDR) && (opcode_c == HLT);
  assign halt       = halt_c;
  assign mem_addr_c = (phase_q < OP_ADDR) ? pc_q : ir_q[AWIDTH-1:0];
  // Reset aborts an in-flight store so memory is never touched by reset.
  assign mem_we_c   = (phase_q == STORE) && (opcode_c == STO) && !rst;

  veri_risc_memory memory_inst (
    .clk_i   (clk),
    .we_i    (mem_we_c),
    .addr_i  (mem_addr_c),
    .wdata_i (acc_q),
    .rdata_o (mem_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= INST_ADDR;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
    end
  end

  // Phase sequencing and per-phase datapath updates.
  always_comb begin
    phase_d = phase_e'(phase_q + 3'd1);
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    case (phase_q)
      INST_LOAD: begin
        ir_d = mem_rdata_c;
      end
      OP_ADDR: begin
        if (opcode_c == HLT) begin
          phase_d = OP_ADDR;
        end else begin
          pc_d = AWIDTH'(pc_q + 5'd1);
        end
      end
      ALU_OP: begin
        if ((opcode_c == SKZ) && zero_c) begin
          pc_d = AWIDTH'(pc_q + 5'd1);
        end
        if (opcode_c == JMP) begin
          pc_d = ir_q[AWIDTH-1:0];
        end
      end
      STORE: begin
        acc_d = alu_calc(opcode_c, acc_q, mem_rdata_c);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_veri_risc.sv
// Directed-program bench for veri_risc: loads memory, runs fixed clock counts, checks halt/state.
module tb_veri_risc;
  import veri_risc_pkg::*;

  logic clk;
  logic rst;
  logic halt;

  int checks;
  int failures;

  veri_risc dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ins(input opcode_e op, input logic [4:0] addr);
    return {op, addr};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) dut.memory_inst.memo[i] = 8'h00;
  endtask

  task automatic wmem(input int a, input logic [7:0] d);
    dut.memory_inst.memo[a] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  // Halt must be low after n clocks and high one clock later.
  task automatic run_check(input string tag, input int n);
    tick(n);
    check({tag, "_pre"}, 32'(halt), 32'd0);
    tick(1);
    check({tag, "_halt"}, 32'(halt), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;

    // Reset
    clear_mem();
    wmem(0, ins(HLT, 5'd0));
    tick(1);
    check("rst_during", 32'(halt), 32'd0);
    rst = 1'b0;
    tick(1);
    check("rst_after", 32'(halt), 32'd0);
    check("rst_phase", 32'(dut.phase_q), 32'd1);

    // HLT
    clear_mem();
    wmem(0, ins(HLT, 5'd0));
    do_reset();
    run_check("hlt", 2);

    // JMP
    clear_mem();
    wmem(0, ins(JMP, 5'd2));
    wmem(1, ins(JMP, 5'd2));
    wmem(2, ins(HLT, 5'd0));
    do_reset();
    run_check("jmp", 10);
    check("jmp_pc", 32'(dut.pc_q), 32'd2);

    // SKZ with acc=0 skips address 1
    clear_mem();
    wmem(0, ins(SKZ, 5'd0));
    wmem(1, ins(JMP, 5'd2));
    wmem(2, ins(HLT, 5'd0));
    do_reset();
    run_check("skz", 10);

    // LDA
    clear_mem();
    wmem(0, ins(LDA, 5'd5));
    wmem(1, ins(SKZ, 5'd0));
    wmem(2, ins(HLT, 5'd0));
    wmem(3, ins(JMP, 5'd4));
    wmem(4, ins(HLT, 5'd0));
    wmem(5, 8'd1);
    do_reset();
    run_check("lda", 18);
    check("lda_acc", 32'(dut.acc_q), 32'd1);

    // STO
    clear_mem();
    wmem(0, ins(LDA, 5'd7));
    wmem(1, ins(STO, 5'd8));
    wmem(2, ins(LDA, 5'd8));
    wmem(3, ins(SKZ, 5'd0));
    wmem(4, ins(HLT, 5'd0));
    wmem(7, 8'd1);
    wmem(8, 8'd0);
    do_reset();
    run_check("sto", 34);
    check("sto_mem8", 32'(dut.memory_inst.memo[8]), 32'd1);

    // ADD with wrap to zero, then nonzero
    clear_mem();
    wmem(0, ins(LDA, 5'd9));
    wmem(1, ins(ADD, 5'd11));
    wmem(2, ins(SKZ, 5'd0));
    wmem(3, ins(HLT, 5'd0));
    wmem(4, ins(ADD, 5'd11));
    wmem(5, ins(SKZ, 5'd0));
    wmem(6, ins(HLT, 5'd0));
    wmem(9, 8'hFF);
    wmem(11, 8'h01);
    do_reset();
    run_check("add", 42);
    check("add_acc", 32'(dut.acc_q), 32'd1);
    check("add_pc", 32'(dut.pc_q), 32'd6);

    // Held halt: state frozen for 20 clocks
    tick(20);
    check("hold_halt", 32'(halt), 32'd1);
    check("hold_pc", 32'(dut.pc_q), 32'd6);
    check("hold_acc", 32'(dut.acc_q), 32'd1);
    check("hold_phase", 32'(dut.phase_q), 32'd4);

    // AND: FF&01=01 (no skip), 01&FE=00 (skip), store 0 over AA
    clear_mem();
    wmem(0, ins(LDA, 5'd9));
    wmem(1, ins(AND, 5'd10));
    wmem(2, ins(SKZ, 5'd0));
    wmem(3, ins(AND, 5'd11));
    wmem(4, ins(SKZ, 5'd0));
    wmem(5, ins(HLT, 5'd0));
    wmem(6, ins(JMP, 5'd7));
    wmem(7, ins(STO, 5'd12));
    wmem(8, ins(HLT, 5'd0));
    wmem(9, 8'hFF);
    wmem(10, 8'h01);
    wmem(11, 8'hFE);
    wmem(12, 8'hAA);
    do_reset();
    run_check("and", 58);
    check("and_acc", 32'(dut.acc_q), 32'd0);
    check("and_mem12", 32'(dut.memory_inst.memo[12]), 32'd0);

    // XOR: 55^54=01 (no skip), 01^01=00 (skip)
    clear_mem();
    wmem(0, ins(LDA, 5'd9));
    wmem(1, ins(XOR, 5'd10));
    wmem(2, ins(SKZ, 5'd0));
    wmem(3, ins(XOR, 5'd11));
    wmem(4, ins(SKZ, 5'd0));
    wmem(5, ins(HLT, 5'd0));
    wmem(6, ins(JMP, 5'd7));
    wmem(7, ins(STO, 5'd12));
    wmem(8, ins(HLT, 5'd0));
    wmem(9, 8'h55);
    wmem(10, 8'h54);
    wmem(11, 8'h01);
    wmem(12, 8'hAA);
    do_reset();
    run_check("xor", 58);
    check("xor_acc", 32'(dut.acc_q), 32'd0);
    check("xor_mem12", 32'(dut.memory_inst.memo[12]), 32'd0);

    // Reset during phase 6 of a JMP, then restart from address 0
    clear_mem();
    wmem(0, ins(LDA, 5'd5));
    wmem(1, ins(JMP, 5'd1));
    wmem(5, 8'd3);
    do_reset();
    tick(13);
    check("mid_phase", 32'(dut.phase_q), 32'd6);
    check("mid_acc_pre", 32'(dut.acc_q), 32'd3);
    rst = 1'b1;
    tick(1);
    check("mid_pc", 32'(dut.pc_q), 32'd0);
    check("mid_phase0", 32'(dut.phase_q), 32'd0);
    check("mid_acc", 32'(dut.acc_q), 32'd0);
    check("mid_halt", 32'(halt), 32'd0);
    rst = 1'b0;
    tick(1);
    tick(7);
    check("restart_acc", 32'(dut.acc_q), 32'd3);
    check("restart_pc", 32'(dut.pc_q), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
